// File: rtl/uart_imem_loader_pkg.sv
// Shared definitions for the UART instruction-memory loader.
// Latency: none (types and constants only).
// Backpressure: none.
package loader_pkg;

    // Frame parser states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LEN  = 2'd1,
        S_DATA = 2'd2,
        S_CHK  = 2'd3
    } state_t;

    // Default frame start marker.
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/uart_imem_loader_timeout.sv
// Inter-byte idle watchdog: reloads on every accepted byte, expires after TIMEOUT_CYCLES idle clocks.
// Latency: o_expire is combinational from the count; asserts in the clock where the idle count reaches the limit.
// Backpressure: none; a load in the expiring cycle suppresses the expire.
module loader_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic i_load,
    output logic o_expire
);

    localparam int              CW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0]   RELOAD = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    // Down-count idle clocks; hold at zero until the next reload.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt <= RELOAD;
        end else if (i_load) begin
            r_cnt <= RELOAD;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_expire = (r_cnt == '0) && !i_load;

endmodule

// File: rtl/uart_imem_loader.sv
// Parses SYNC/len/data/xor frames from the UART and writes little-endian words into instruction memory.
// Latency: write strobe one clock after each word's 4th byte; load_done one clock after the checksum byte.
// Backpressure: none; accepts one byte per clock, back-to-back.
module uart_imem_loader
    import loader_pkg::*;
#(
    parameter int         DEPTH          = 64,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wd,
    output logic        core_hold,
    output logic        load_done,
    output logic        load_err
);

    localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    state_t        r_state;
    state_t        w_next;
    logic [IW-1:0] r_word_idx;
    logic [IW-1:0] r_last;      // index of the final word (N-1)
    logic [1:0]    r_byte_idx;
    logic [23:0]   r_word;      // bytes 0..2 of the word being assembled
    logic [7:0]    r_xor;

    logic w_expire;
    logic w_start;
    logic w_len_ok;
    logic w_wr;
    logic w_done;
    logic w_err;
    logic w_data_byte;

    // Watchdog idles while waiting for a frame; any byte reloads it.
    loader_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .i_load   (rx_valid || (r_state == S_IDLE)),
        .o_expire (w_expire)
    );

    assign w_data_byte = (r_state == S_DATA) && rx_valid;

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state and per-byte control strobes; a byte in the expiring cycle beats the timeout.
    always_comb begin
        w_next   = r_state;
        w_start  = 1'b0;
        w_len_ok = 1'b0;
        w_wr     = 1'b0;
        w_done   = 1'b0;
        w_err    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    w_start = 1'b1;
                    w_next  = S_LEN;
                end
            end
            S_LEN: begin
                if (rx_valid) begin
                    if ((rx_data == 8'd0) || (32'(rx_data) > DEPTH_U)) begin
                        w_err  = 1'b1;
                        w_next = S_IDLE;
                    end else begin
                        w_len_ok = 1'b1;
                        w_next   = S_DATA;
                    end
                end else if (w_expire) begin
                    w_err  = 1'b1;
                    w_next = S_IDLE;
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    if (r_byte_idx == 2'd3) begin
                        w_wr = 1'b1;
                        if (r_word_idx == r_last) w_next = S_CHK;
                    end
                end else if (w_expire) begin
                    w_err  = 1'b1;
                    w_next = S_IDLE;
                end
            end
            S_CHK: begin
                if (rx_valid) begin
                    if (rx_data == r_xor) w_done = 1'b1;
                    else                  w_err  = 1'b1;
                    w_next = S_IDLE;
                end else if (w_expire) begin
                    w_err  = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Frame datapath: word assembly, checksum accumulation and the registered memory write port.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            imem_we    <= 1'b0;
            imem_addr  <= 32'd0;
            imem_wd    <= 32'd0;
            core_hold  <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            r_word_idx <= '0;
            r_last     <= '0;
            r_byte_idx <= 2'd0;
            r_word     <= 24'd0;
            r_xor      <= 8'd0;
        end else begin
            imem_we   <= w_wr;
            load_done <= w_done;
            if (w_start) begin
                core_hold <= 1'b1;
                load_err  <= 1'b0;
            end
            if (w_err)  load_err  <= 1'b1;
            if (w_done) core_hold <= 1'b0;
            if (w_len_ok) begin
                r_last     <= IW'(rx_data - 8'd1);
                r_word_idx <= '0;
                r_byte_idx <= 2'd0;
                r_xor      <= 8'd0;
            end
            if (w_data_byte) begin
                r_xor      <= r_xor ^ rx_data;
                r_byte_idx <= r_byte_idx + 2'd1;
                case (r_byte_idx)
                    2'd0:    r_word[7:0]   <= rx_data;
                    2'd1:    r_word[15:8]  <= rx_data;
                    2'd2:    r_word[23:16] <= rx_data;
                    default: begin
                        imem_wd    <= {rx_data, r_word};
                        imem_addr  <= 32'({r_word_idx, 2'b00});
                        r_word_idx <= r_word_idx + IW'(1);
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed bench for uart_imem_loader: frames, errors, timeout, reset abort.
// Latency: checks sampled 1 time unit after the active edge.
// Backpressure: none.
module tb_uart_imem_loader;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wd;
    logic        core_hold;
    logic        load_done;
    logic        load_err;

    always #5 CLK = ~CLK;

    uart_imem_loader #(
        .DEPTH          (64),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wd   (imem_wd),
        .core_hold (core_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Write-port monitor, sampled on the falling edge.
    logic [31:0] we_addr_q[$];
    logic [31:0] we_wd_q[$];
    int          we_cyc_q[$];
    int          done_cnt = 0;
    int          overlap_cnt = 0;
    always @(negedge CLK) begin
        if (imem_we) begin
            we_addr_q.push_back(imem_addr);
            we_wd_q.push_back(imem_wd);
            we_cyc_q.push_back(cyc);
        end
        if (load_done) done_cnt++;
        if (imem_we && load_done) overlap_cnt++;
    end

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_wd[64];
    int          exp_cyc[64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge CLK);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic clear_mon();
        we_addr_q.delete();
        we_wd_q.delete();
        we_cyc_q.delete();
    endtask

    // Sends a complete frame of n words (word i = seed + i*0x01010101) back-to-back.
    task automatic send_frame(input int n, input logic [31:0] seed, input bit bad_chk);
        logic [7:0]  x;
        logic [31:0] w;
        x = 8'h00;
        send(8'hA5);
        send(8'(n));
        for (int i = 0; i < n; i++) begin
            w = seed + 32'(i) * 32'h0101_0101;
            exp_wd[i] = w;
            for (int k = 0; k < 4; k++) begin
                send(w[8*k +: 8]);
                x = x ^ w[8*k +: 8];
            end
            exp_cyc[i] = cyc;
        end
        send(bad_chk ? ~x : x);
    endtask

    task automatic check_writes(input string tag, input int n);
        chk($sformatf("%s_we_count", tag), 32'(we_addr_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < we_addr_q.size()) begin
                chk($sformatf("%s_addr%0d", tag, i), we_addr_q[i], 32'(i * 4));
                chk($sformatf("%s_wd%0d", tag, i), we_wd_q[i], exp_wd[i]);
                chk($sformatf("%s_lat%0d", tag, i), 32'(we_cyc_q[i]), 32'(exp_cyc[i]));
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_we"},   {31'd0, imem_we},   32'd0);
        chk({tag, "_addr"}, imem_addr,          32'd0);
        chk({tag, "_wd"},   imem_wd,            32'd0);
        chk({tag, "_hold"}, {31'd0, core_hold}, 32'd0);
        chk({tag, "_done"}, {31'd0, load_done}, 32'd0);
        chk({tag, "_err"},  {31'd0, load_err},  32'd0);
    endtask

    logic [7:0] bad_len[2];
    int         d0;

    initial begin
        bad_len[0] = 8'h00;
        bad_len[1] = 8'h41;
        RST_N    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        idle(3);
        check_reset_outputs("rst");
        RST_N = 1'b1;
        idle(2);

        // Single-word frame A5 01 93 00 10 00 83.
        clear_mon();
        send_frame(1, 32'h0010_0093, 1'b0);
        chk("a_done",  {31'd0, load_done}, 32'd1);
        chk("a_hold",  {31'd0, core_hold}, 32'd0);
        chk("a_err",   {31'd0, load_err},  32'd0);
        check_writes("a", 1);
        idle(1);
        chk("a_done_pulse", {31'd0, load_done}, 32'd0);

        // Full-depth frame, 256 data bytes back-to-back.
        clear_mon();
        d0 = done_cnt;
        send_frame(64, 32'h0302_0100, 1'b0);
        chk("b_done", {31'd0, load_done}, 32'd1);
        chk("b_hold", {31'd0, core_hold}, 32'd0);
        check_writes("b", 64);
        idle(2);
        chk("b_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Checksum flipped; words include SYNC-valued bytes treated as data.
        clear_mon();
        d0 = done_cnt;
        send_frame(3, 32'hA5A5_A5A5, 1'b1);
        chk("c_err",  {31'd0, load_err},  32'd1);
        chk("c_hold", {31'd0, core_hold}, 32'd1);
        chk("c_done", {31'd0, load_done}, 32'd0);
        check_writes("c", 3);
        idle(2);
        chk("c_done_cnt", 32'(done_cnt - d0), 32'd0);

        // Illegal lengths, then a recovering frame.
        for (int j = 0; j < 2; j++) begin
            clear_mon();
            send(8'hA5);
            chk($sformatf("d%0d_err_clr", j), {31'd0, load_err},  32'd0);
            chk($sformatf("d%0d_hold", j),    {31'd0, core_hold}, 32'd1);
            send(bad_len[j]);
            chk($sformatf("d%0d_err", j),     {31'd0, load_err},  32'd1);
            send(8'h11);
            send(8'h22);
            send(8'h33);
            send(8'h44);
            idle(2);
            chk($sformatf("d%0d_no_we", j), 32'(we_addr_q.size()), 32'd0);
            chk($sformatf("d%0d_err_held", j), {31'd0, load_err}, 32'd1);
            send_frame(2, 32'h1234_5678, 1'b0);
            chk($sformatf("d%0d_rec_done", j), {31'd0, load_done}, 32'd1);
            chk($sformatf("d%0d_rec_err", j),  {31'd0, load_err},  32'd0);
            chk($sformatf("d%0d_rec_hold", j), {31'd0, core_hold}, 32'd0);
            check_writes($sformatf("d%0d", j), 2);
        end

        // Inter-byte timeout of 16 idle clocks.
        clear_mon();
        send(8'hA5);
        send(8'h01);
        send(8'h11);
        send(8'h22);
        idle(15);
        chk("e_err_15", {31'd0, load_err}, 32'd0);
        idle(1);
        chk("e_err_16", {31'd0, load_err},  32'd1);
        chk("e_hold",   {31'd0, core_hold}, 32'd1);
        chk("e_no_we",  32'(we_addr_q.size()), 32'd0);
        send_frame(1, 32'hCAFE_F00D, 1'b0);
        chk("e_rec_done", {31'd0, load_done}, 32'd1);
        chk("e_rec_err",  {31'd0, load_err},  32'd0);
        check_writes("e", 1);

        // Byte arriving in the expiring cycle wins over the timeout.
        clear_mon();
        send(8'hA5);
        send(8'h01);
        send(8'h44);
        idle(15);
        send(8'h55);
        chk("f_err_race", {31'd0, load_err}, 32'd0);
        send(8'h66);
        send(8'h77);
        exp_wd[0]  = 32'h7766_5544;
        exp_cyc[0] = cyc;
        send(8'h00);
        chk("f_done", {31'd0, load_done}, 32'd1);
        chk("f_err",  {31'd0, load_err},  32'd0);
        check_writes("f", 1);

        // Reset in the middle of DATA aborts the frame.
        clear_mon();
        send(8'hA5);
        send(8'h01);
        send(8'h33);
        send(8'h44);
        RST_N = 1'b0;
        #1;
        check_reset_outputs("g");
        idle(2);
        RST_N = 1'b1;
        idle(1);
        send(8'h55);
        send(8'h66);
        send(8'h00);
        idle(3);
        chk("g_no_we", 32'(we_addr_q.size()), 32'd0);
        chk("g_hold",  {31'd0, core_hold}, 32'd0);
        chk("g_err",   {31'd0, load_err},  32'd0);

        chk("we_done_overlap", 32'(overlap_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
